// File: rtl/bcd_score_accumulator.sv
// Multi-digit BCD score register: ripple-carry add of a BCD addend one digit per
// cycle, saturation at all nines, then a leading-zero-blanked display copy.
module bcd_score_accumulator #(
  parameter int DIGITS        = 8,
  parameter int ADD_DIGITS    = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    clear_in,
  input  logic                    start_in,
  input  logic [4*ADD_DIGITS-1:0] addend_in,
  output logic [4*DIGITS-1:0]     score_out,
  output logic [4*DIGITS-1:0]     display_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    overflow_out
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [IW-1:0] FIRST_IDX = IW'(1);
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [W-1:0]  DISP_RESET =
    BLANK_LEADING ? {{(DIGITS-1){4'hA}}, 4'h0} : {W{1'b0}};

  typedef enum logic [1:0] {IDLE, ADD, BLANK, DONE} state_t;

  state_t            state, state_next;
  logic [W-1:0]      score, addend, addend_clean;
  logic [W-1:0]      display, display_next;
  logic [IW-1:0]     idx;
  logic              carry, leading, overflow;
  logic [DIGITS-1:0] mask, mask_next;
  logic [3:0]        score_digit, addend_digit;
  logic [4:0]        add_res;
  logic              blank_here;

  // Non-BCD codes (A-F) count as zero so a blanked digit fed back reads as 0.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  // Returns {carry_out, digit}; digit is always a legal BCD value.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] s;
    s = 5'(a) + 5'(b) + 5'(cin);
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return {1'b0, s[3:0]};
  endfunction

  function automatic logic [W-1:0] blank_digits(input logic [W-1:0]      s,
                                                input logic [DIGITS-1:0] m);
    logic [W-1:0] r;
    for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = m[d] ? 4'hA : s[4*d +: 4];
    return r;
  endfunction

  always_comb begin
    addend_clean = '0;
    for (int d = 0; d < ADD_DIGITS; d++)
      addend_clean[4*d +: 4] = bcd_sanitize(addend_in[4*d +: 4]);
  end

  // One shared digit index serves both the upward add and the downward scan.
  always_comb begin
    score_digit  = score[{idx, 2'b00} +: 4];
    addend_digit = addend[{idx, 2'b00} +: 4];
    add_res      = bcd_digit_add(score_digit, addend_digit, carry);
    blank_here   = BLANK_LEADING && leading && (score_digit == 4'd0);
    mask_next    = mask;
    if (state == BLANK) mask_next[idx] = blank_here;
    display_next = blank_digits(score, mask_next);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_out   = (state != IDLE);
    done_out   = (state == DONE);
    case (state)
      IDLE:    if (start_in) state_next = ADD;
      ADD:     if (idx == LAST_IDX) state_next = BLANK;
      BLANK:   if (idx == FIRST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear_in) state_next = IDLE;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      score    <= '0;
      addend   <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      leading  <= 1'b1;
      mask     <= '0;
      display  <= DISP_RESET;
      overflow <= 1'b0;
    end else if (clear_in) begin
      score    <= '0;
      addend   <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      leading  <= 1'b1;
      mask     <= '0;
      display  <= DISP_RESET;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            addend  <= addend_clean;
            idx     <= '0;
            carry   <= 1'b0;
            leading <= 1'b1;
            mask    <= '0;
          end
        end
        ADD: begin
          score[{idx, 2'b00} +: 4] <= add_res[3:0];
          carry                    <= add_res[4];
          if (idx == LAST_IDX) begin
            // Final digit carry-out: clamp the whole score, later NBA wins.
            if (add_res[4]) begin
              score    <= ALL_NINES;
              overflow <= 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        BLANK: begin
          mask    <= mask_next;
          leading <= blank_here;
          idx     <= idx - 1'b1;
          if (idx == FIRST_IDX) display <= display_next;
        end
        default: ;
      endcase
    end
  end

  assign score_out    = score;
  assign display_out  = display;
  assign overflow_out = overflow;

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Scoreboard bench: three accumulator instances (blanking on/off, and a wide-addend
// variant for saturation); expected results are queued per start, popped on done.
module tb_bcd_score_accumulator;

  typedef struct {
    logic [31:0] score;
    logic [31:0] disp;
    logic [31:0] disp_nb;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clear, start, clear_w, start_w;
  logic [15:0] addend;
  logic [31:0] addend_w;
  logic [31:0] score, display, score_nb, display_nb, score_w, display_w;
  logic        busy, done, ovf, busy_nb, done_nb, ovf_nb, busy_w, done_w, ovf_w;

  exp_t q[$];
  exp_t q_w[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_cnt = 0;
  int   busy_cnt_w = 0;

  bcd_score_accumulator #(.DIGITS(8), .ADD_DIGITS(4), .BLANK_LEADING(1'b1)) dut (
    .clk_in(clk), .rst_in(rst), .clear_in(clear), .start_in(start),
    .addend_in(addend), .score_out(score), .display_out(display),
    .busy_out(busy), .done_out(done), .overflow_out(ovf));

  bcd_score_accumulator #(.DIGITS(8), .ADD_DIGITS(4), .BLANK_LEADING(1'b0)) dut_nb (
    .clk_in(clk), .rst_in(rst), .clear_in(clear), .start_in(start),
    .addend_in(addend), .score_out(score_nb), .display_out(display_nb),
    .busy_out(busy_nb), .done_out(done_nb), .overflow_out(ovf_nb));

  bcd_score_accumulator #(.DIGITS(8), .ADD_DIGITS(8), .BLANK_LEADING(1'b1)) dut_w (
    .clk_in(clk), .rst_in(rst), .clear_in(clear_w), .start_in(start_w),
    .addend_in(addend_w), .score_out(score_w), .display_out(display_w),
    .busy_out(busy_w), .done_out(done_w), .overflow_out(ovf_w));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      else      busy_cnt = 0;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("score", score, e.score);
          chk("display", display, e.disp);
          chk("overflow", 32'(ovf), 32'(e.ovf));
          chk("latency", 32'(busy_cnt), 32'd16);
          chk("nb_done", 32'(done_nb), 32'd1);
          chk("nb_score", score_nb, e.score);
          chk("nb_display", display_nb, e.disp_nb);
        end
        busy_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt_w = 0;
    end else begin
      if (busy_w) busy_cnt_w++;
      else        busy_cnt_w = 0;
      if (done_w) begin
        if (q_w.size() == 0) begin
          chk("w_unexpected_done", 32'(done_w), 32'd0);
        end else begin
          exp_t e;
          e = q_w.pop_front();
          chk("w_score", score_w, e.score);
          chk("w_display", display_w, e.disp);
          chk("w_overflow", 32'(ovf_w), 32'(e.ovf));
          chk("w_latency", 32'(busy_cnt_w), 32'd16);
        end
        busy_cnt_w = 0;
      end
    end
  end

  task automatic drain(input bit wide);
    int n;
    n = 0;
    while ((wide ? q_w.size() : q.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if ((wide ? q_w.size() : q.size()) != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done_out within %0d cycles (wide=%0d)", n, wide);
      if (wide) q_w.delete();
      else      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic add_main(input logic [15:0] a, input logic [31:0] es,
                          input logic [31:0] ed, input logic [31:0] edn, input logic eo);
    exp_t e;
    e = '{score: es, disp: ed, disp_nb: edn, ovf: eo};
    q.push_back(e);
    @(negedge clk); start = 1'b1; addend = a;
    @(negedge clk); start = 1'b0;
    drain(1'b0);
  endtask

  task automatic add_wide(input logic [31:0] a, input logic [31:0] es,
                          input logic [31:0] ed, input logic eo);
    exp_t e;
    e = '{score: es, disp: ed, disp_nb: ed, ovf: eo};
    q_w.push_back(e);
    @(negedge clk); start_w = 1'b1; addend_w = a;
    @(negedge clk); start_w = 1'b0;
    drain(1'b1);
  endtask

  task automatic idle_main(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; addend = '0;
    clear_w = 1'b0; start_w = 1'b0; addend_w = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_score", score, 32'h0);
    chk("rst_display", display, 32'hAAAAAAA0);
    chk("rst_display_nb", display_nb, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);
    chk("rst_display_w", display_w, 32'hAAAAAAA0);

    add_main(16'h0001, 32'h00000001, 32'hAAAAAAA1, 32'h00000001, 1'b0);
    add_main(16'h0998, 32'h00000999, 32'hAAAAA999, 32'h00000999, 1'b0);
    add_main(16'h0001, 32'h00001000, 32'hAAAA1000, 32'h00001000, 1'b0);

    // Second start during ADD must be ignored; display holds while busy.
    q.push_back('{score: 32'h00001005, disp: 32'hAAAA1005, disp_nb: 32'h00001005, ovf: 1'b0});
    @(negedge clk); start = 1'b1; addend = 16'h0005;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("display_hold", display, 32'hAAAA1000);
    start = 1'b1; addend = 16'h0007;
    @(negedge clk); start = 1'b0;
    drain(1'b0);
    idle_main(20);

    add_main(16'h9999, 32'h00011004, 32'hAAA11004, 32'h00011004, 1'b0);

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_score", score, 32'h0);
    chk("clr_display", display, 32'hAAAAAAA0);
    chk("clr_busy", 32'(busy), 32'd0);

    add_main(16'h00A5, 32'h00000005, 32'hAAAAAAA5, 32'h00000005, 1'b0);

    // Clear aborts an add in progress.
    @(negedge clk); start = 1'b1; addend = 16'h0002;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("abort_score", score, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_display", display, 32'hAAAAAAA0);
    idle_main(20);

    add_main(16'h0004, 32'h00000004, 32'hAAAAAAA4, 32'h00000004, 1'b0);

    // start and clear together: clear wins.
    @(negedge clk); start = 1'b1; clear = 1'b1; addend = 16'h0009;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    chk("prio_score", score, 32'h0);
    chk("prio_busy", 32'(busy), 32'd0);
    idle_main(20);

    // Asynchronous reset in the middle of BLANK, checked before the next edge.
    @(negedge clk); start = 1'b1; addend = 16'h0003;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_score", score, 32'h0);
    chk("arst_display", display, 32'hAAAAAAA0);
    chk("arst_display_nb", display_nb, 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_overflow", 32'(ovf), 32'd0);
    @(negedge clk); rst = 1'b0;
    idle_main(20);

    add_main(16'h0001, 32'h00000001, 32'hAAAAAAA1, 32'h00000001, 1'b0);

    // Saturation and sticky overflow on the wide-addend instance.
    add_wide(32'h99999990, 32'h99999990, 32'h99999990, 1'b0);
    add_wide(32'h00000025, 32'h99999999, 32'h99999999, 1'b1);
    add_wide(32'h00000001, 32'h99999999, 32'h99999999, 1'b1);
    add_wide(32'h00000000, 32'h99999999, 32'h99999999, 1'b1);
    @(negedge clk); clear_w = 1'b1;
    @(negedge clk); clear_w = 1'b0;
    chk("w_clr_overflow", 32'(ovf_w), 32'd0);
    chk("w_clr_score", score_w, 32'h0);
    chk("w_clr_display", display_w, 32'hAAAAAAA0);

    idle_main(5);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("queue_w_empty", 32'(q_w.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_score_accumulator.md
# bcd_score_accumulator

Parametrised multi-digit BCD score register for the Tetris display path. It adds a multi-digit BCD addend (line-clear points, drop bonus) to the running score, one digit per cycle with ripple carry. It saturates at all nines on overflow and then produces a display copy with leading zeroes blanked to 4'hA for the seven-segment driver. It replaces the single-step increment counter.

## Interface
- DIGITS, 8: score width in BCD digits (≥2); score is 4*DIGITS bits.
- ADD_DIGITS, 4: addend width in BCD digits (1..DIGITS); zero-extended to DIGITS.
- BLANK_LEADING, 1: 1 = blank leading zeroes in display_out with 4'hA; 0 = display_out mirrors score_out.
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- clear_in  input  1  synchronous score clear (new game).
- start_in  input  1  request to add addend_in; sampled only in IDLE.
- addend_in  input  4*ADD_DIGITS  BCD addend, digit 0 in [3:0].
- score_out  output  4*DIGITS  raw BCD score, always valid BCD.
- display_out  output  4*DIGITS  blanked display copy.
- busy_out  output  1  high from the cycle after start acceptance until return to IDLE.
- done_out  output  1  one-cycle pulse in the DONE cycle.
- overflow_out  output  1  sticky saturation flag.

## Operation
- States: IDLE, ADD, BLANK, DONE.
- Reset and clear values:
  - score_out = 0, busy_out = 0, done_out = 0, overflow_out = 0, state = IDLE.
  - display_out = {(DIGITS-1){4'hA}, 4'h0} if BLANK_LEADING, else 0.
- IDLE:
  - When start_in = 1, latch addend_in. Any addend digit > 9 is latched as 0, so 4'hA reads as zero.
  - Clear digit index i = 0 and carry = 0, then go to ADD.
- ADD, one digit per cycle, i = 0..DIGITS-1:
  - s = score[i] + addend[i] + carry (5-bit, max 19).
  - If s > 9: score[i] = s-10, carry = 1. Otherwise score[i] = s, carry = 0.
  - On the last digit, if carry-out = 1: score_out = all 4'h9 and overflow_out = 1.
  - Go to BLANK.
- BLANK, DIGITS-1 cycles, scanning j = DIGITS-1 down to 1:
  - A leading flag starts at 1.
  - If leading and score[j] = 0, mark digit j blank. Otherwise clear leading.
  - Digit 0 is never blanked.
  - With BLANK_LEADING = 0 nothing is marked, but the same cycle count is spent so latency stays fixed.
- DONE:
  - display_out is loaded from score_out with marked digits replaced by 4'hA.
  - done_out = 1, then go to IDLE.
- clear_in:
  - Valid in any state; aborts any operation in progress.
  - Forces the reset values except that rst_in semantics are not involved.
  - Clears overflow_out.
- Priority: rst_in > clear_in > start_in. start_in while busy is ignored, not queued.

## Timing
- start_in sampled high in IDLE at edge k → busy_out = 1 after edge k.
- ADD occupies edges k+1 .. k+DIGITS.
- BLANK occupies the following DIGITS-1 edges.
- DONE cycle follows; busy_out and done_out are both high during it.
- busy_out is high for exactly 2*DIGITS cycles (16 for DIGITS = 8).
- busy_out falls and state returns to IDLE on the edge ending DONE. A new start_in can be accepted in that next cycle.
- score_out holds partial sums during ADD; consumers sample on done_out.
- display_out changes only on the DONE edge, on clear, or on reset. It holds the old value while busy.
- Overflow saturation is applied on the final ADD edge. overflow_out rises on that edge and stays high until clear_in or rst_in.
- rst_in asserts asynchronously with no clock edge needed and releases synchronously to normal operation on the next edge.

## Test plan
All cases use DIGITS = 8, ADD_DIGITS = 4, BLANK_LEADING = 1.
- Single add from reset:
  - Stimulus: after reset, start with addend 16'h0001.
  - Response: done_out pulses 16 cycles after acceptance; score_out = 32'h00000001, display_out = 32'hAAAAAAA1.
- Ripple carry:
  - Stimulus: score 32'h00000999, add 16'h0001.
  - Response: score_out = 32'h00001000, display_out = 32'hAAAA1000.
- Saturation:
  - Stimulus: score 32'h99999990, add 16'h0025.
  - Response: score_out = 32'h99999999, overflow_out = 1 (sticky across a further add of 16'h0001), display_out = 32'h99999999.
- Invalid addend digit:
  - Stimulus: add 16'h00A5 to 0.
  - Response: score_out = 32'h00000005.
- Start and clear priority:
  - Stimulus: start_in pulses mid-ADD.
  - Response: ignored; only one done_out, and the sum is unchanged.
  - Stimulus: start_in and clear_in in the same IDLE cycle.
  - Response: clear wins; score_out = 0, busy_out = 0, no done_out.
- Asynchronous reset:
  - Stimulus: rst_in asserted mid-BLANK between clock edges.
  - Response: all outputs at reset values before the next edge.
  - Repeat test 1 with BLANK_LEADING = 0: display_out = 32'h00000001.
